mem_data_responder: RTL and testbench
=====================================

MEM_DATA_RESPONDER -- requirements
Module: mem_data_responder

Interface
REQ-001 The block SHALL have one parameter: LATENCY, default 2, the number of wait cycles between request accept and response (legal range 0..15).
REQ-002 The block SHALL have the port Clock_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port Reset_n_in, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have the port MEM_REQ, input, 1 bit: the requester presents a valid request.
REQ-005 The block SHALL have the port MEM_WE, input, 1 bit: 1 means write, 0 means read; sampled with MEM_REQ.
REQ-006 The block SHALL have the port MEM_ADDRESS, input, 32 bits: word address.
REQ-007 The block SHALL have the port MEM_WDATA, input, 32 bits: write data.
REQ-008 The block SHALL have the port MEM_READY, output, 1 bit: the responder can accept a request this cycle.
REQ-009 The block SHALL have the port MEM_ACK, output, 1 bit: one-cycle pulse marking transaction completion.
REQ-010 The block SHALL have the port MEM_ERR, output, 1 bit: out-of-range address, valid only while MEM_ACK=1.
REQ-011 The block SHALL have the port MEM_RDATA, output, 32 bits: read data, registered.

Function
REQ-012 Storage SHALL be 1024 words x 32 bits, indexed by MEM_ADDRESS[9:0].
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-014 MEM_READY SHALL be 1 in IDLE only, and 0 in WAIT and RESP.
REQ-015 Accept: on a rising edge with MEM_REQ=1 and MEM_READY=1, the block SHALL capture MEM_WE, MEM_ADDRESS and MEM_WDATA into internal registers.
REQ-016 Accept transitions: the FSM SHALL go to WAIT with the wait counter loaded to LATENCY-1, or go directly to RESP if LATENCY=0.
REQ-017 In WAIT, the counter SHALL decrement each cycle; when the counter is 0 the next edge SHALL enter RESP.
REQ-018 Access commit: the memory access SHALL occur on the edge entering RESP, using only the captured values; input changes after accept SHALL be ignored.
REQ-019 In RESP, MEM_ACK SHALL be 1 for exactly one cycle, and the next edge SHALL return to IDLE unconditionally.
REQ-020 Latency: MEM_ACK SHALL go high LATENCY+1 cycles after the accept edge; minimum request-to-request spacing SHALL be LATENCY+2 cycles.
REQ-021 Read, in range: MEM_RDATA SHALL equal mem[addr] during the ACK cycle and hold until the next ACK.
REQ-022 Write, in range: the captured data SHALL be written to mem[addr], and MEM_RDATA SHALL be unchanged.
REQ-023 Out-of-range (captured MEM_ADDRESS[31:10] != 0): MEM_ERR SHALL be 1 with ACK; there SHALL be no write (no aliasing onto [9:0]), and MEM_RDATA SHALL be 0.
REQ-024 Read-after-write: a read accepted after the write's ACK SHALL return the newly written value.
REQ-025 MEM_REQ=1 held continuously SHALL be accepted once per IDLE visit; requests while MEM_READY=0 SHALL be ignored, not queued.
REQ-026 MEM_ERR SHALL be 0 whenever MEM_ACK=0.

Reset
REQ-027 While Reset_n_in=0, immediately and asynchronously, the block SHALL force: FSM=IDLE, counter=0, MEM_ACK=0, MEM_ERR=0, MEM_RDATA=0, and MEM_READY=1 (IDLE).
REQ-028 Reset mid-transaction (WAIT or RESP before commit) SHALL discard the pending access; an uncommitted write SHALL never reach memory.
REQ-029 Memory array contents SHALL NOT be cleared by reset, and SHALL be undefined after power-up until written.
REQ-030 The first request SHALL be accepted on the first rising edge after Reset_n_in returns to 1.

Verification (LATENCY=2 unless stated)
REQ-031 Write 0xDEADBEEF @0x005, then read @0x005 -> each ACK 3 cycles after its accept; read RDATA=0xDEADBEEF, ERR=0; RDATA unchanged on the write ACK.
REQ-032 Write 0x11111111 @0x000, then write 0x22222222 @0x400, then read @0x000 -> the second ACK has ERR=1, RDATA=0; the final read returns 0x11111111 (no alias).
REQ-033 MEM_REQ held 1 for four reads @0x3FC..0x3FF -> exactly four ACKs, spaced 4 cycles apart; READY low in WAIT/RESP; address 0x3FF is accessed without error.
REQ-034 Write 0xA5A5A5A5 @0x010, then write 0x12345678 @0x010 with reset pulsed during WAIT -> outputs return to reset values at once with no ACK; a read @0x010 after reset returns 0xA5A5A5A5.
REQ-035 LATENCY=0: read accepted at edge N -> ACK high in the cycle after N, READY=1 again at N+2.
REQ-036 MEM_REQ asserted in RESP with MEM_ADDRESS=0x020 and deasserted before IDLE -> no transaction, no extra ACK.

Source files
------------

// File: rtl/mem_data_responder.sv
// mem_data_responder: 1024x32 memory responder with fixed request-to-ack latency
module mem_data_responder #(
  parameter int LATENCY = 2
) (
  input  logic        Clock_in,
  input  logic        Reset_n_in,
  input  logic        MEM_REQ,
  input  logic        MEM_WE,
  input  logic [31:0] MEM_ADDRESS,
  input  logic [31:0] MEM_WDATA,
  output logic        MEM_READY,
  output logic        MEM_ACK,
  output logic        MEM_ERR,
  output logic [31:0] MEM_RDATA
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY == 0 ? 0 : LATENCY - 1);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
  logic err_q, err_d;
  logic [31:0] mem [1024];
  logic accept, commit, c_we, c_oor;
  logic [31:0] c_addr, c_wdata;
  assign accept = state_q == IDLE && MEM_REQ;
  assign commit = (accept && LATENCY == 0) || (state_q == WAIT && cnt_q == 4'd0);
  // With zero latency the commit edge is the accept edge, so the live inputs are the captured values
  assign c_we    = state_q == IDLE ? MEM_WE : we_q;
  assign c_addr  = state_q == IDLE ? MEM_ADDRESS : addr_q;
  assign c_wdata = state_q == IDLE ? MEM_WDATA : wdata_q;
  assign c_oor   = c_addr[31:10] != 22'd0;
  assign MEM_READY = state_q == IDLE;
  assign MEM_ACK   = state_q == RESP;
  assign MEM_ERR   = state_q == RESP && err_q;
  assign MEM_RDATA = rdata_q;
  // Next state, wait counter and response data decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = LATENCY == 0 ? RESP : WAIT;
      cnt_d   = LAT_M1;
    end else if (state_q == WAIT) begin
      state_d = cnt_q == 4'd0 ? RESP : WAIT;
      cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
    rdata_d = commit ? (c_oor ? 32'd0 : (c_we ? rdata_q : mem[c_addr[9:0]])) : rdata_q;
    err_d   = commit ? c_oor : err_q;
  end
  // State, request capture and response registers; reset drops any pending access
  always_ff @(posedge Clock_in or negedge Reset_n_in) begin
    if (!Reset_n_in) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= MEM_WE;
        addr_q  <= MEM_ADDRESS;
        wdata_q <= MEM_WDATA;
      end
    end
  end
  // Storage is never cleared; out-of-range writes are dropped rather than aliased
  always_ff @(posedge Clock_in) begin
    if (commit && c_we && !c_oor) mem[c_addr[9:0]] <= c_wdata;
  end
endmodule

// File: tb/tb_mem_data_responder.sv
// tb_mem_data_responder: scoreboard bench for mem_data_responder
module tb_mem_data_responder;
  localparam int LAT = 2;
  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0, we = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic ready, ack, err;
  logic [31:0] rdata;
  logic req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
  logic ready0, ack0, err0;
  logic [31:0] rdata0;
  int cyc = 0;
  int n_asrt = 0, n_fail = 0;
  exp_t sb[$];
  logic [31:0] mdl [1024];
  logic [31:0] last_rd = 32'd0;

  mem_data_responder #(.LATENCY(LAT)) dut (
    .Clock_in(clk), .Reset_n_in(rst_n), .MEM_REQ(req), .MEM_WE(we),
    .MEM_ADDRESS(addr), .MEM_WDATA(wdata), .MEM_READY(ready), .MEM_ACK(ack),
    .MEM_ERR(err), .MEM_RDATA(rdata)
  );
  mem_data_responder #(.LATENCY(0)) dut0 (
    .Clock_in(clk), .Reset_n_in(rst_n), .MEM_REQ(req0), .MEM_WE(we0),
    .MEM_ADDRESS(addr0), .MEM_WDATA(wdata0), .MEM_READY(ready0), .MEM_ACK(ack0),
    .MEM_ERR(err0), .MEM_RDATA(rdata0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following the accept edge
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input bit hold, input bit push, output int waits);
    exp_t e;
    req = 1'b1; we = w; addr = a; wdata = d;
    waits = 0;
    while (!ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      req = 1'b0;
      return;
    end
    if (push) begin
      e.cyc = cyc + LAT + 1;
      if (a[31:10] != 22'd0) begin
        e.err = 1'b1;
        last_rd = 32'd0;
      end else begin
        e.err = 1'b0;
        if (w) mdl[a[9:0]] = d;
        else last_rd = mdl[a[9:0]];
      end
      e.rdata = last_rd;
      sb.push_back(e);
    end
    @(negedge clk);
    if (!hold) req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ack) begin
        if (sb.size() == 0) check("spurious_ack", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_cycle", cyc, e.cyc);
          check("ack_err", {31'd0, err}, {31'd0, e.err});
          check("ack_rdata", rdata, e.rdata);
          check("ready_in_resp", {31'd0, ready}, 32'd0);
        end
      end else if (err) check("err_without_ack", {31'd0, err}, 32'd0);
    end
  end

  initial begin
    int w;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    issue(1'b1, 32'h005, 32'hDEADBEEF, 1'b0, 1'b1, w);
    check("first_accept_waits", w, 32'd0);
    issue(1'b0, 32'h005, 32'd0, 1'b0, 1'b1, w);
    issue(1'b1, 32'h000, 32'h11111111, 1'b0, 1'b1, w);
    issue(1'b1, 32'h400, 32'h22222222, 1'b0, 1'b1, w);
    issue(1'b0, 32'h000, 32'd0, 1'b0, 1'b1, w);
    for (int i = 0; i < 4; i++) issue(1'b1, 32'h3FC + i, 32'hC0DE0000 + i, 1'b0, 1'b1, w);
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 32'h3FC + i, 32'd0, i < 3, 1'b1, w);
      if (i > 0) check("held_req_spacing", w, 32'd3);
    end
    issue(1'b1, 32'h010, 32'hA5A5A5A5, 1'b0, 1'b1, w);
    issue(1'b1, 32'h010, 32'h12345678, 1'b0, 1'b0, w);
    rst_n = 1'b0;
    last_rd = 32'd0;
    #1;
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_ack", {31'd0, ack}, 32'd0);
    check("midrst_err", {31'd0, err}, 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 32'h010, 32'd0, 1'b0, 1'b1, w);
    check("post_rst_accept_waits", w, 32'd0);
    issue(1'b0, 32'h005, 32'd0, 1'b0, 1'b1, w);
    @(negedge clk);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h020;
    @(negedge clk);
    req = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_ready", {31'd0, ready}, 32'd1);
    check("l0_ready_idle", {31'd0, ready0}, 32'd1);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h003; wdata0 = 32'hCAFEF00D;
    @(negedge clk);
    req0 = 1'b0;
    check("l0_write_ack", {31'd0, ack0}, 32'd1);
    check("l0_write_ready", {31'd0, ready0}, 32'd0);
    check("l0_write_rdata", rdata0, 32'd0);
    @(negedge clk);
    check("l0_ready_again", {31'd0, ready0}, 32'd1);
    req0 = 1'b1; we0 = 1'b0;
    @(negedge clk);
    req0 = 1'b0;
    check("l0_read_ack", {31'd0, ack0}, 32'd1);
    check("l0_read_err", {31'd0, err0}, 32'd0);
    check("l0_read_rdata", rdata0, 32'hCAFEF00D);
    @(negedge clk);
    check("l0_read_ready", {31'd0, ready0}, 32'd1);
    check("l0_ack_pulse", {31'd0, ack0}, 32'd0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("sb_drain", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
